// File: rtl/usb_tx_pkg.sv
// Shared line-state types, constants and FSM encoding for the low-speed USB transmitter.
package usb_tx_pkg;

    typedef logic [1:0] d_port_t;   // {D-, D+}

    localparam d_port_t J   = 2'b10;
    localparam d_port_t K   = 2'b01;
    localparam d_port_t SE0 = 2'b00;

    localparam int STUFF_LIMIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } usb_tx_state_t;

endpackage

// File: rtl/usb_tx_nrzi.sv
// NRZI encoder with consecutive-ones tracking; o_level is the line level the strobed bit produces.
module usb_tx_nrzi
    import usb_tx_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_bit,
    input  logic    i_strobe,
    input  logic    i_sync_start,
    output d_port_t o_level,
    output logic    o_stuff_req
);

    d_port_t    r_level;
    logic [2:0] r_ones;

    d_port_t    w_base;
    logic [2:0] w_ones_base;

    // A new packet always encodes from an idle J with no ones history.
    assign w_base      = i_sync_start ? J : r_level;
    assign w_ones_base = i_sync_start ? 3'd0 : r_ones;
    assign o_level     = i_bit ? w_base : ~w_base;
    assign o_stuff_req = (r_ones == 3'(STUFF_LIMIT));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= J;
            r_ones  <= 3'd0;
        end else if (i_strobe) begin
            r_level <= o_level;
            r_ones  <= i_bit ? (w_ones_base + 3'd1) : 3'd0;
        end
    end

endmodule

// File: rtl/usb_tx.sv
// Low-speed USB transmitter: SYNC, LSB-first NRZI data with bit stuffing, EOP; drives D+/D- with enable.
// state   | meaning
// IDLE    | line released, waiting for tx_valid
// SYNC    | 8 sync bits (KJKJKJKK)
// DATA    | data bit r_bit_idx of the current byte on the line
// STUFF   | stuffed 0 after six ones, following data bit r_bit_idx
// EOP_SE0 | SE0 for two bit times
// EOP_J   | J for one bit time, then release
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic       o_tx_err,
    output logic       o_busy,
    output d_port_t    o_d_o,
    output logic       o_d_en
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    usb_tx_state_t r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_last;
    logic          r_loaded;
    logic          r_tx_ready;
    logic          r_tx_err;
    logic          r_busy;
    logic          r_d_en;
    d_port_t       r_d_o;

    logic    w_bit_end;
    logic    w_pre_end;
    logic    w_accept;
    logic    w_byte_end;
    logic    w_stb;
    logic    w_bit;
    logic    w_sync_start;
    d_port_t w_level;
    logic    w_stuff_req;

    assign w_bit_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_pre_end  = (r_clk_cnt == CW'(CLKS_PER_BIT - 2));
    assign w_accept   = r_tx_ready && i_tx_valid;
    assign w_byte_end = ((r_state == ST_DATA && !w_stuff_req) || r_state == ST_STUFF)
                        && (r_bit_idx == 3'd7);

    // Bit that the line carries next; strobed into the encoder on the edge that starts it.
    always_comb begin
        w_stb        = 1'b0;
        w_bit        = 1'b0;
        w_sync_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stb        = i_tx_valid;
                w_sync_start = i_tx_valid;
            end
            ST_SYNC: begin
                if (w_bit_end && r_bit_idx != 3'd7) begin
                    w_stb = 1'b1;
                    w_bit = (r_bit_idx == 3'd6);
                end else if (w_bit_end && r_loaded) begin
                    w_stb = 1'b1;
                    w_bit = r_shift[0];
                end
            end
            ST_DATA, ST_STUFF: begin
                if (w_bit_end) begin
                    if (r_state == ST_DATA && w_stuff_req) begin
                        w_stb = 1'b1;
                    end else if (r_bit_idx != 3'd7) begin
                        w_stb = 1'b1;
                        w_bit = r_shift[1];
                    end else if (!r_last && w_accept) begin
                        w_stb = 1'b1;
                        w_bit = i_tx_data[0];
                    end
                end
            end
            default: ;
        endcase
    end

    usb_tx_nrzi u_nrzi (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_bit        (w_bit),
        .i_strobe     (w_stb),
        .i_sync_start (w_sync_start),
        .o_level      (w_level),
        .o_stuff_req  (w_stuff_req)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_last     <= 1'b0;
            r_loaded   <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_err   <= 1'b0;
            r_busy     <= 1'b0;
            r_d_en     <= 1'b0;
            r_d_o      <= J;
        end else begin
            r_tx_ready <= 1'b0;
            r_tx_err   <= 1'b0;
            r_clk_cnt  <= w_bit_end ? '0 : r_clk_cnt + CW'(1);
            if (w_stb) r_d_o <= w_level;
            // Raise ready one clock early so it is high on the final clock of the byte.
            if (w_pre_end && w_byte_end && !r_last) r_tx_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_loaded  <= 1'b0;
                    if (i_tx_valid) begin
                        r_state    <= ST_SYNC;
                        r_bit_idx  <= 3'd0;
                        r_d_en     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_accept) begin
                        r_shift  <= i_tx_data;
                        r_last   <= i_tx_last;
                        r_loaded <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            if (r_loaded) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_tx_err <= 1'b1;
                                r_state  <= ST_EOP_SE0;
                                r_d_o    <= SE0;
                            end
                        end
                    end
                end
                ST_DATA, ST_STUFF: begin
                    if (w_bit_end) begin
                        if (r_state == ST_DATA && w_stuff_req) begin
                            r_state <= ST_STUFF;
                        end else if (r_bit_idx != 3'd7) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                        end else if (r_last) begin
                            r_state   <= ST_EOP_SE0;
                            r_bit_idx <= 3'd0;
                            r_d_o     <= SE0;
                        end else if (w_accept) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                            r_shift   <= i_tx_data;
                            r_last    <= i_tx_last;
                        end else begin
                            r_tx_err  <= 1'b1;
                            r_state   <= ST_EOP_SE0;
                            r_bit_idx <= 3'd0;
                            r_d_o     <= SE0;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd1) begin
                            r_state   <= ST_EOP_J;
                            r_bit_idx <= 3'd0;
                            r_d_o     <= J;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (w_bit_end) begin
                        r_state <= ST_IDLE;
                        r_d_en  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_tx_err   = r_tx_err;
    assign o_busy     = r_busy;
    assign o_d_o      = r_d_o;
    assign o_d_en     = r_d_en;

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: line symbols sampled mid-bit, enable length, handshake and error pulses.
module tb_usb_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       o_tx_ready;
    logic       o_tx_err;
    logic       o_busy;
    logic [1:0] o_d_o;
    logic       o_d_en;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [0:3];
    string      got_line;
    int         den_cnt, busy_cnt, rdy_cnt, err_cnt, err_k;
    int         rdy_k [0:3];
    bit         timed_out;

    always #5 clk = ~clk;

    usb_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tx_valid (tx_valid),
        .i_tx_data  (tx_data),
        .i_tx_last  (tx_last),
        .o_tx_ready (o_tx_ready),
        .o_tx_err   (o_tx_err),
        .o_busy     (o_busy),
        .o_d_o      (o_d_o),
        .o_d_en     (o_d_en)
    );

    function automatic string sym(input logic [1:0] v);
        case (v)
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    // Sends pkt[0..n-1]; with underrun=1 the last byte is flagged not-last and valid then drops.
    task automatic run_packet(input int n, input bit underrun);
        int  k, idx;
        bit  started, done, adv;
        got_line = "";
        den_cnt = 0; busy_cnt = 0; rdy_cnt = 0; err_cnt = 0; err_k = -1000;
        for (int i = 0; i < 4; i++) rdy_k[i] = -1000;
        repeat (3) begin @(posedge clk); #1; end
        idx = 0; k = 0; started = 0; done = 0;
        tx_data  = pkt[0];
        tx_last  = (n == 1) && !underrun;
        tx_valid = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            adv = o_tx_ready && tx_valid;
            if (o_tx_ready) begin
                if (rdy_cnt < 4) rdy_k[rdy_cnt] = k;
                rdy_cnt++;
            end
            if (o_tx_err) begin err_cnt++; err_k = k; end
            if (o_busy) busy_cnt++;
            if (o_d_en) begin
                started = 1;
                den_cnt++;
                if (k % CPB == CPB / 2) got_line = {got_line, sym(o_d_o)};
                k++;
            end else if (started) begin
                done = 1;
            end
            @(posedge clk); #1;
            if (adv) begin
                idx++;
                if (idx < n) begin
                    tx_data = pkt[idx];
                    tx_last = (idx == n - 1) && !underrun;
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
        tx_valid  = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        checks += 5;
        if (o_d_en !== 1'b0)    begin errors++; $display("FAIL reset_d_en got %b exp 0", o_d_en); end
        if (o_d_o !== 2'b10)    begin errors++; $display("FAIL reset_d_o got %b exp 10", o_d_o); end
        if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b exp 0", o_tx_ready); end
        if (o_tx_err !== 1'b0)  begin errors++; $display("FAIL reset_tx_err got %b exp 0", o_tx_err); end
    endtask

    task automatic test_single(input string name, input logic [7:0] data,
                               input string exp_line, input int exp_den);
        pkt[0] = data;
        run_packet(1, 1'b0);
        checks += 6;
        if (timed_out) begin errors++; $display("FAIL %s_timeout got 1 exp 0", name); end
        if (got_line != exp_line) begin
            errors++; $display("FAIL %s_line got %s exp %s", name, got_line, exp_line);
        end
        if (den_cnt != exp_den) begin errors++; $display("FAIL %s_d_en_len got %0d exp %0d", name, den_cnt, exp_den); end
        if (busy_cnt != exp_den) begin errors++; $display("FAIL %s_busy_len got %0d exp %0d", name, busy_cnt, exp_den); end
        if (rdy_cnt != 1) begin errors++; $display("FAIL %s_ready_cnt got %0d exp 1", name, rdy_cnt); end
        if (err_cnt != 0) begin errors++; $display("FAIL %s_err_cnt got %0d exp 0", name, err_cnt); end
    endtask

    task automatic test_back_to_back();
        pkt[0] = 8'h2D; pkt[1] = 8'h00;
        run_packet(2, 1'b0);
        checks += 6;
        if (timed_out) begin errors++; $display("FAIL b2b_timeout got 1 exp 0"); end
        if (got_line != "KJKJKJKKKJJJKKJKJKJKJKJK00J") begin
            errors++; $display("FAIL b2b_line got %s exp KJKJKJKKKJJJKKJKJKJKJKJK00J", got_line);
        end
        if (den_cnt != 27 * CPB) begin errors++; $display("FAIL b2b_d_en_len got %0d exp %0d", den_cnt, 27 * CPB); end
        if (rdy_cnt != 2) begin errors++; $display("FAIL b2b_ready_cnt got %0d exp 2", rdy_cnt); end
        // First ready is on clk 0 of SYNC, second on the last clk of byte 0: 16 bits minus one clk.
        if (rdy_k[1] - rdy_k[0] != 16 * CPB - 1) begin
            errors++; $display("FAIL b2b_ready_gap got %0d exp %0d", rdy_k[1] - rdy_k[0], 16 * CPB - 1);
        end
        if (err_cnt != 0) begin errors++; $display("FAIL b2b_err_cnt got %0d exp 0", err_cnt); end
    endtask

    task automatic test_underrun();
        pkt[0] = 8'h2D;
        run_packet(1, 1'b1);
        checks += 6;
        if (timed_out) begin errors++; $display("FAIL underrun_timeout got 1 exp 0"); end
        if (got_line != "KJKJKJKKKJJJKKJK00J") begin
            errors++; $display("FAIL underrun_line got %s exp KJKJKJKKKJJJKKJK00J", got_line);
        end
        if (den_cnt != 19 * CPB) begin errors++; $display("FAIL underrun_d_en_len got %0d exp %0d", den_cnt, 19 * CPB); end
        if (rdy_cnt != 2 || rdy_k[1] != 16 * CPB - 1) begin
            errors++; $display("FAIL underrun_ready got cnt %0d at %0d exp cnt 2 at %0d", rdy_cnt, rdy_k[1], 16 * CPB - 1);
        end
        if (err_cnt != 1) begin errors++; $display("FAIL underrun_err_cnt got %0d exp 1", err_cnt); end
        if (err_k != 16 * CPB) begin errors++; $display("FAIL underrun_err_time got %0d exp %0d", err_k, 16 * CPB); end
    endtask

    task automatic test_reset_mid();
        tx_data = 8'hC3; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (98) begin @(posedge clk); #1; end
        checks += 1;
        if (o_d_en !== 1'b1) begin errors++; $display("FAIL midreset_active got %b exp 1", o_d_en); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks += 4;
        if (o_d_en !== 1'b0) begin errors++; $display("FAIL midreset_d_en got %b exp 0", o_d_en); end
        if (o_d_o !== 2'b10) begin errors++; $display("FAIL midreset_d_o got %b exp 10", o_d_o); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", o_busy); end
        if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL midreset_tx_ready got %b exp 0", o_tx_ready); end
        reset = 1'b0;
        test_single("after_reset", 8'hC3, "KJKJKJKKKKJKJKKK00J", 19 * CPB);
    endtask

    initial begin
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        test_reset();
        reset = 1'b0;
        test_single("c3", 8'hC3, "KJKJKJKKKKJKJKKK00J", 19 * CPB);
        test_single("ff", 8'hFF, "KJKJKJKKKKKKKJJJJ00J", 20 * CPB);
        test_single("fc", 8'hFC, "KJKJKJKKJKKKKKKKJ00J", 20 * CPB);
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
